// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//
// Top-level game control FSM. Once per video frame it waits for the frame tick
// from the datapath, then steps the datapath through movement generation,
// collision check, link action, enemy movement and the three draw passes
// (map, link, enemies). Each state is presented to the datapath as a one-hot
// strobe. A per-pass watchdog aborts a draw pass that never reports done.
//
// Ports:
//   clock              system clock
//   reset              synchronous, active-high reset
//   pause              hold the game in IDLE while high
//   idle_done          frame tick from the datapath
//   draw_map_done      map pass complete
//   draw_link_done     link pass complete
//   draw_enemies_done  enemy pass complete
//   init .. draw_enemies  one-hot state strobes (exactly one high per cycle)
//   frame_count        number of completed (non-aborted) frames, wraps
//   draw_timeout       sticky watchdog error flag, cleared only by reset
//   state_code         current state encoding for debug
// -----------------------------------------------------------------------------
module frame_sequencer #(
    parameter int          INIT_CYCLES    = 4,
    parameter int          COLLIDE_CYCLES = 2,
    parameter logic [19:0] DRAW_TIMEOUT   = 20'd400000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pause,
    input  logic        idle_done,
    input  logic        draw_map_done,
    input  logic        draw_link_done,
    input  logic        draw_enemies_done,
    output logic        init,
    output logic        idle,
    output logic        gen_move,
    output logic        check_collide,
    output logic        apply_act_link,
    output logic        move_enemies,
    output logic        draw_map,
    output logic        draw_link,
    output logic        draw_enemies,
    output logic [15:0] frame_count,
    output logic        draw_timeout,
    output logic [3:0]  state_code
);

    typedef enum logic [3:0] {
        ST_INIT          = 4'd0,
        ST_IDLE          = 4'd1,
        ST_GEN_MOVE      = 4'd2,
        ST_CHECK_COLLIDE = 4'd3,
        ST_APPLY_LINK    = 4'd4,
        ST_MOVE_ENEMIES  = 4'd5,
        ST_DRAW_MAP      = 4'd6,
        ST_DRAW_LINK     = 4'd7,
        ST_DRAW_ENEMIES  = 4'd8
    } state_t;

    // Last value of the shared cycle counter before leaving a timed state.
    localparam logic [19:0] INIT_LAST    = 20'(INIT_CYCLES - 1);
    localparam logic [19:0] COLLIDE_LAST = 20'(COLLIDE_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = DRAW_TIMEOUT - 20'd1;

    // One-hot strobe pattern for a state; bit index equals the state code.
    // Anything unrecognised decodes to the init strobe, matching the
    // recovery path of an illegal state.
    function automatic logic [8:0] decode_strobes(input state_t s);
        logic [8:0] v;
        case (s)
            ST_INIT:          v = 9'b0_0000_0001;
            ST_IDLE:          v = 9'b0_0000_0010;
            ST_GEN_MOVE:      v = 9'b0_0000_0100;
            ST_CHECK_COLLIDE: v = 9'b0_0000_1000;
            ST_APPLY_LINK:    v = 9'b0_0001_0000;
            ST_MOVE_ENEMIES:  v = 9'b0_0010_0000;
            ST_DRAW_MAP:      v = 9'b0_0100_0000;
            ST_DRAW_LINK:     v = 9'b0_1000_0000;
            ST_DRAW_ENEMIES:  v = 9'b1_0000_0000;
            default:          v = 9'b0_0000_0001;
        endcase
        return v;
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic [19:0] cnt_r;
    logic [19:0] cnt_next_s;
    logic [8:0]  strobe_r;
    logic [15:0] frame_count_r;
    logic        draw_timeout_r;
    logic        frame_inc_s;
    logic        abort_s;
    logic        done_sel_s;
    logic        done_ok_s;
    logic        timeout_hit_s;

    // Matching done for the current draw pass; only meaningful in draw states.
    always_comb begin
        done_sel_s = 1'b0;
        case (state_r)
            ST_DRAW_MAP:     done_sel_s = draw_map_done;
            ST_DRAW_LINK:    done_sel_s = draw_link_done;
            ST_DRAW_ENEMIES: done_sel_s = draw_enemies_done;
            default:         done_sel_s = 1'b0;
        endcase
    end

    // A done in the first cycle of a draw state may be stale from the previous
    // frame, so it only qualifies once the counter has moved past zero.
    assign done_ok_s     = done_sel_s && (cnt_r != 20'd0);
    assign timeout_hit_s = (cnt_r >= TIMEOUT_LAST);

    // Next-state logic plus frame-complete and abort events.
    always_comb begin
        next_state_s = state_r;
        frame_inc_s  = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (cnt_r >= INIT_LAST) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                // A tick while paused is dropped, not queued.
                if (idle_done && !pause) begin
                    next_state_s = ST_GEN_MOVE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_GEN_MOVE: begin
                next_state_s = ST_CHECK_COLLIDE;
            end
            ST_CHECK_COLLIDE: begin
                if (cnt_r >= COLLIDE_LAST) begin
                    next_state_s = ST_APPLY_LINK;
                end else begin
                    next_state_s = ST_CHECK_COLLIDE;
                end
            end
            ST_APPLY_LINK: begin
                next_state_s = ST_MOVE_ENEMIES;
            end
            ST_MOVE_ENEMIES: begin
                next_state_s = ST_DRAW_MAP;
            end
            ST_DRAW_MAP, ST_DRAW_LINK, ST_DRAW_ENEMIES: begin
                // Done takes priority over the watchdog when both land together.
                if (done_ok_s) begin
                    if (state_r == ST_DRAW_MAP) begin
                        next_state_s = ST_DRAW_LINK;
                    end else if (state_r == ST_DRAW_LINK) begin
                        next_state_s = ST_DRAW_ENEMIES;
                    end else begin
                        next_state_s = ST_IDLE;
                        frame_inc_s  = 1'b1;
                    end
                end else if (timeout_hit_s) begin
                    next_state_s = ST_IDLE;
                    abort_s      = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = ST_INIT;
            end
        endcase
    end

    // Shared residency counter: restarts on every state change.
    always_comb begin
        cnt_next_s = 20'd0;
        if (next_state_s != state_r) begin
            cnt_next_s = 20'd0;
        end else begin
            cnt_next_s = cnt_r + 20'd1;
        end
    end

    // State, counter and strobe registers; strobes are pre-decoded from the
    // next state so they stay aligned with state_r while coming from flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_INIT;
            cnt_r    <= 20'd0;
            strobe_r <= decode_strobes(ST_INIT);
        end else begin
            state_r  <= next_state_s;
            cnt_r    <= cnt_next_s;
            strobe_r <= decode_strobes(next_state_s);
        end
    end

    // Completed-frame counter and sticky watchdog flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count_r  <= 16'd0;
            draw_timeout_r <= 1'b0;
        end else begin
            if (frame_inc_s) begin
                frame_count_r <= frame_count_r + 16'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
            if (abort_s) begin
                draw_timeout_r <= 1'b1;
            end else begin
                draw_timeout_r <= draw_timeout_r;
            end
        end
    end

    assign init           = strobe_r[0];
    assign idle           = strobe_r[1];
    assign gen_move       = strobe_r[2];
    assign check_collide  = strobe_r[3];
    assign apply_act_link = strobe_r[4];
    assign move_enemies   = strobe_r[5];
    assign draw_map       = strobe_r[6];
    assign draw_link      = strobe_r[7];
    assign draw_enemies   = strobe_r[8];
    assign frame_count    = frame_count_r;
    assign draw_timeout   = draw_timeout_r;
    assign state_code     = state_r;

endmodule
